// File: rtl/wb_burst_reader_if.sv
// Wishbone B3 bus bundle shared by the burst reader and its slaves.
// Master drives cycle/strobe/address; slave returns ack/err/rty and data.
interface wishbone_b3 #(
  parameter int DW = 32,
  parameter int AW = 32
);
  logic          cyc;
  logic          stb;
  logic          we;
  logic [3:0]    sel;
  logic [AW-1:0] adr;
  logic [2:0]    cti;
  logic [1:0]    bte;
  logic [DW-1:0] dat_m2s;
  logic [DW-1:0] dat_s2m;
  logic          ack;
  logic          err;
  logic          rty;

  modport master (
    output cyc, stb, we, sel, adr, cti, bte, dat_m2s,
    input  ack, err, rty, dat_s2m
  );

  modport slave (
    input  cyc, stb, we, sel, adr, cti, bte, dat_m2s,
    output ack, err, rty, dat_s2m
  );
endinterface

// File: rtl/wb_burst_reader.sv
// Wishbone B3 burst reader: fetches a word block into a FIFO and
// streams it out, sizing each burst to the FIFO space left.
module wb_burst_reader #(
  parameter int data_width = 32,
  parameter int addr_width = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  wishbone_b3.master            bus,
  input  logic                  start_i,
  input  logic [addr_width-1:0] base_addr_i,
  input  logic [15:0]           word_count_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o,
  output logic [data_width-1:0] out_data_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int WA = addr_width - 2;

  typedef enum logic [2:0] {
    IDLE, PLAN, BURST, GAP, FINISH
  } state_t;

  state_t          state_q, state_d;
  logic [WA-1:0]   wadr_q, wadr_d;
  logic [15:0]     rem_q, rem_d;
  logic [BW-1:0]   beats_q, beats_d;
  logic            single_q, single_d;
  logic            err_q, err_d;
  logic            busy_q, busy_d;
  logic            done_q;

  logic [data_width-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]   wp_q, rp_q;
  logic [PW:0]     cnt_q;

  logic            push, pop, fault;
  logic [16:0]     free, plan_len;
  logic            unused_lsb;

  assign unused_lsb = ^base_addr_i[1:0];
  assign fault = bus.err | bus.rty;
  assign push  = (state_q == BURST) & bus.ack & ~fault;
  assign pop   = (cnt_q != '0) & out_ready_i;

  // A pop in the planning cycle already counts as freed space.
  always_comb begin
    free     = 17'(FIFO_DEPTH) - 17'(cnt_q) + 17'(pop);
    plan_len = {1'b0, rem_q};
    if (plan_len > 17'(MAX_BURST)) plan_len = 17'(MAX_BURST);
    if (plan_len > free)           plan_len = free;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      wadr_q   <= '0;
      rem_q    <= '0;
      beats_q  <= '0;
      single_q <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wadr_q   <= wadr_d;
      rem_q    <= rem_d;
      beats_q  <= beats_d;
      single_q <= single_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      done_q   <= (state_q == FINISH);
    end
  end

  always_comb begin
    state_d  = state_q;
    wadr_d   = wadr_q;
    rem_d    = rem_q;
    beats_d  = beats_q;
    single_d = single_q;
    err_d    = err_q;
    busy_d   = busy_q;
    unique case (state_q)
      IDLE: if (start_i) begin
        wadr_d  = base_addr_i[addr_width-1:2];
        rem_d   = word_count_i;
        err_d   = 1'b0;
        busy_d  = 1'b1;
        state_d = (word_count_i == 16'd0) ? FINISH : PLAN;
      end
      PLAN: if (plan_len != 17'd0) begin
        beats_d  = BW'(plan_len);
        single_d = (plan_len == 17'd1);
        state_d  = BURST;
      end
      BURST: begin
        if (fault) begin
          err_d   = 1'b1;
          state_d = FINISH;
        end else if (bus.ack) begin
          wadr_d  = wadr_q + WA'(1);
          rem_d   = rem_q - 16'd1;
          beats_d = beats_q - BW'(1);
          if (beats_q == BW'(1))
            state_d = (rem_q != 16'd1) ? GAP : FINISH;
        end
      end
      GAP: state_d = PLAN;
      FINISH: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.cyc     = (state_q == BURST);
    bus.stb     = bus.cyc;
    bus.we      = 1'b0;
    bus.sel     = 4'b1111;
    bus.bte     = 2'b00;
    bus.dat_m2s = '0;
    bus.adr     = {wadr_q, 2'b00};
    bus.cti     = 3'b000;
    if (state_q == BURST && !single_q)
      bus.cti = (beats_q == BW'(1)) ? 3'b111 : 3'b010;
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wp_q] <= bus.dat_s2m;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wp_q <= wp_q + PW'(1);
      if (pop)  rp_q <= rp_q + PW'(1);
      if (push && !pop)      cnt_q <= cnt_q + (PW+1)'(1);
      else if (pop && !push) cnt_q <= cnt_q - (PW+1)'(1);
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign error_o     = err_q;
  assign out_data_o  = mem_q[rp_q];
  assign out_valid_o = (cnt_q != '0);
endmodule

// File: tb/tb_wb_burst_reader.sv
// Directed bench for wb_burst_reader against a data=address slave.
// Bus beats, burst lengths and stream words are logged at negedge.
module tb_wb_burst_reader;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] base = '0;
  logic [15:0] wcnt = '0;
  logic        ordy = 1'b0;
  logic        busy, done, error, ovalid;
  logic [31:0] odata;

  always #5 clk = ~clk;

  wishbone_b3 #(.DW(32), .AW(32)) bus ();

  wb_burst_reader #(
    .data_width(32), .addr_width(32),
    .FIFO_DEPTH(8), .MAX_BURST(4)
  ) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus),
    .start_i(start), .base_addr_i(base),
    .word_count_i(wcnt), .busy_o(busy),
    .done_o(done), .error_o(error),
    .out_data_o(odata), .out_valid_o(ovalid),
    .out_ready_i(ordy)
  );

  // zero-wait slave, optional err on beat index err_at
  int err_at = 99;
  int bcnt = 0;
  assign bus.ack     = bus.cyc & (bcnt != err_at);
  assign bus.err     = bus.cyc & (bcnt == err_at);
  assign bus.rty     = 1'b0;
  assign bus.dat_s2m = bus.adr;

  always @(posedge clk) begin
    if (rst || !bus.cyc) bcnt <= 0;
    else if (bus.ack)    bcnt <= bcnt + 1;
  end

  logic [34:0] beat_q[$];
  int          burst_q[$];
  logic [31:0] rx_q[$];
  int done_cnt = 0;
  int cur_len = 0;
  int cyc_cnt = 0;
  int occ = 0;
  int max_occ = 0;

  always @(negedge clk) begin
    if (!bus.cyc && cur_len > 0) begin
      burst_q.push_back(cur_len);
      cur_len = 0;
    end
    if (bus.cyc) begin
      cyc_cnt++;
      if (bus.ack || bus.err) cur_len++;
      if (bus.ack) beat_q.push_back({bus.cti, bus.adr});
    end
    if (done) done_cnt++;
    if (ovalid && ordy) rx_q.push_back(odata);
    if (rst) occ = 0;
    else occ += ((bus.cyc && bus.ack) ? 1 : 0)
              - ((ovalid && ordy) ? 1 : 0);
    if (occ > max_occ) max_occ = occ;
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear();
    beat_q.delete();
    burst_q.delete();
    rx_q.delete();
    done_cnt = 0;
    cyc_cnt = 0;
    max_occ = 0;
  endtask

  task automatic do_start(input logic [31:0] b,
                          input logic [15:0] n);
    @(posedge clk); #1;
    start = 1'b1; base = b; wcnt = n;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (done) break;
    end
    chk("done_seen", done, 1);
  endtask

  task automatic settle();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic chk_rx(input string tag,
                        input logic [31:0] b,
                        input int n);
    chk({tag, "_rxn"}, rx_q.size(), n);
    for (int i = 0; i < n && i < rx_q.size(); i++)
      chk({tag, "_rx"}, rx_q[i], b + 32'(4 * i));
  endtask

  task automatic chk_beat(input string tag, input int i,
                          input logic [2:0] cti,
                          input logic [31:0] adr);
    if (i < beat_q.size()) chk(tag, beat_q[i], {cti, adr});
    else chk({tag, "_missing"}, beat_q.size(), i + 1);
  endtask

  task automatic chk_lens(input string tag, input int l0,
                          input int l1, input int l2);
    int exp[$];
    exp.push_back(l0);
    if (l1 > 0) exp.push_back(l1);
    if (l2 > 0) exp.push_back(l2);
    chk({tag, "_nburst"}, burst_q.size(), exp.size());
    for (int i = 0; i < exp.size() && i < burst_q.size(); i++)
      chk({tag, "_len"}, burst_q[i], exp[i]);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cyc", bus.cyc, 0);
    chk("rst_stb", bus.stb, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", error, 0);
    chk("rst_valid", ovalid, 0);
    chk("rst_adr", bus.adr, 0);
    chk("rst_cti", bus.cti, 0);
    rst = 1'b0;
    ordy = 1'b1;

    // three-word burst, latency and cti sequence
    clear();
    do_start(32'h100, 3);
    chk("lat_busy", busy, 1);
    chk("lat_cyc_c1", bus.cyc, 0);
    @(posedge clk); #1;
    chk("lat_cyc_c2", bus.cyc, 1);
    chk("lat_stb_c2", bus.stb, 1);
    wait_done(40);
    chk("t1_busy_end", busy, 0);
    settle();
    chk_beat("t1_b0", 0, 3'b010, 32'h100);
    chk_beat("t1_b1", 1, 3'b010, 32'h104);
    chk_beat("t1_b2", 2, 3'b111, 32'h108);
    chk_lens("t1", 3, 0, 0);
    chk_rx("t1", 32'h100, 3);
    chk("t1_done", done_cnt, 1);
    chk("t1_err", error, 0);

    // ten words split 4/4/2, start while busy ignored
    clear();
    do_start(32'h200, 10);
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1; base = 32'hF00; wcnt = 5;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(100);
    settle();
    chk_lens("t2", 4, 4, 2);
    chk_rx("t2", 32'h200, 10);
    chk("t2_done", done_cnt, 1);

    // back-pressure: FIFO fills to 8 then bus idles
    ordy = 1'b0;
    clear();
    do_start(32'h1000, 20);
    repeat (40) @(posedge clk);
    #1;
    chk("t3_beats", beat_q.size(), 8);
    chk("t3_cyc", bus.cyc, 0);
    chk("t3_busy", busy, 1);
    chk("t3_valid", ovalid, 1);
    chk("t3_data", odata, 32'h1000);
    ordy = 1'b1;
    wait_done(400);
    settle();
    chk_rx("t3", 32'h1000, 20);
    chk("t3_no_ovf", max_occ <= 8, 1);
    chk("t3_done", done_cnt, 1);

    // err on second beat of a 4-beat burst
    clear();
    err_at = 1;
    do_start(32'h40, 8);
    wait_done(50);
    chk("t4_err_at_done", error, 1);
    settle();
    err_at = 99;
    chk_lens("t4", 2, 0, 0);
    chk_rx("t4", 32'h40, 1);
    chk("t4_done", done_cnt, 1);
    chk("t4_err_sticky", error, 1);

    // single word: classic cycle, error cleared by start
    clear();
    do_start(32'h0, 1);
    chk("t5_err_clr", error, 0);
    wait_done(40);
    settle();
    chk_beat("t5_b0", 0, 3'b000, 32'h0);
    chk_lens("t5", 1, 0, 0);
    chk_rx("t5", 32'h0, 1);

    // zero-length request
    clear();
    do_start(32'h80, 0);
    chk("z_busy_c1", busy, 1);
    chk("z_done_c1", done, 0);
    @(posedge clk); #1;
    chk("z_done_c2", done, 1);
    chk("z_busy_c2", busy, 0);
    settle();
    chk("z_no_cyc", cyc_cnt, 0);
    chk("z_done_cnt", done_cnt, 1);

    // reset in the middle of a burst
    ordy = 1'b0;
    clear();
    do_start(32'h300, 8);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("r_pre_cyc", bus.cyc, 1);
    chk("r_pre_valid", ovalid, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("r_cyc", bus.cyc, 0);
    chk("r_valid", ovalid, 0);
    chk("r_busy", busy, 0);
    chk("r_adr", bus.adr, 0);
    chk("r_cti", bus.cti, 0);
    rst = 1'b0;
    ordy = 1'b1;
    @(posedge clk); #1;
    clear();
    do_start(32'h500, 2);
    wait_done(40);
    settle();
    chk_beat("r_b0", 0, 3'b010, 32'h500);
    chk_beat("r_b1", 1, 3'b111, 32'h504);
    chk_rx("r", 32'h500, 2);
    chk("r_done", done_cnt, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/wb_burst_reader.md
# wb_burst_reader

Wishbone B3 master that fetches a block of 32-bit words from a Wishbone slave (ROM or RAM) using incrementing-address bursts and delivers them, in order, on a valid/ready output stream through an internal FIFO. A single `start` pulse sets the byte base address and word count. The block splits the transfer into bursts sized to the free FIFO space, so the bus is never stalled mid-burst. It sits between the system bus and stream consumers such as a table loader or a display feeder.

## Interface
- `data_width`, 32, bus and stream data width; `sel` is 4 bits.
- `addr_width`, 32, byte-address width of `bus.adr` and `base_addr`.
- `FIFO_DEPTH`, 8, output FIFO entries; must be a power of 2 and at least 2.
- `MAX_BURST`, 4, maximum beats per Wishbone cycle; must be at least 1.
- `clk`  in  1  Single clock; all logic is on the rising edge.
- `rst`  in  1  Synchronous, active-high reset.
- `bus`  wishbone_b3.master  -  Drives `cyc, stb, we, sel, adr, cti, bte, dat_m2s`; samples `ack, err, rty, dat_s2m`.
- `start`  in  1  Single-cycle request; ignored while `busy` is 1.
- `base_addr`  in  addr_width  Byte address of the first word; bits [1:0] are ignored (treated as 0).
- `word_count`  in  16  Number of words to read; 0 is legal.
- `busy`  out  1  High from the cycle after an accepted `start` until the cycle `done` pulses.
- `done`  out  1  One-cycle pulse when the transfer ends, on success or on error.
- `error`  out  1  Sticky error flag; set when the slave asserts `err` or `rty`; cleared on the next accepted `start`.
- `out_data`  out  data_width  FIFO head.
- `out_valid`  out  1  FIFO not empty.
- `out_ready`  in  1  Consumer pop; a pop occurs when `out_valid & out_ready`.

## Operation
- Fixed bus outputs:
  - `we` = 0, `sel` = 4'b1111, `bte` = 2'b00, `dat_m2s` = 0.
  - `stb` = `cyc` at all times.
- State machine: IDLE, PLAN, BURST, GAP, FINISH.
- **IDLE**
  - On `start`: latch the word address (`base_addr` >> 2) and `word_count` into `remaining`, clear `error`, set `busy`.
  - If `word_count` = 0, go to FINISH; otherwise go to PLAN.
- **PLAN**
  - Compute L = min(`remaining`, `MAX_BURST`, free FIFO slots). Free slots count a same-cycle pop as freed.
  - If L = 0, stay in PLAN.
  - Otherwise load the beat counter with L, assert `cyc`, and go to BURST.
- **BURST**
  - `cyc` is held high continuously; `adr` = word address << 2.
  - `cti` = 3'b010 while more than one beat remains, and 3'b111 on the final beat.
  - When L = 1, `cti` = 3'b000 (classic single read).
  - On each cycle with `ack`:
    - Push `dat_s2m` into the FIFO.
    - Increment the word address.
    - Decrement `remaining` and the beat counter.
  - On the final ack: drop `cyc`. Go to GAP if `remaining` > 0, otherwise to FINISH.
- **Error**
  - `err` or `rty` during BURST takes priority over `ack`.
  - Set `error`, push no data, drop `cyc` the next cycle, and go to FINISH.
  - Remaining words are abandoned.
- **GAP**: one idle cycle with `cyc` = 0, then go to PLAN.
- **FINISH**: pulse `done`, clear `busy`, go to IDLE.
- **FIFO**
  - Pointer-based, with a count 0..`FIFO_DEPTH`.
  - Push and pop in the same cycle leave the count unchanged.
  - Push when full cannot occur by construction; verification asserts this.
  - The FIFO keeps its contents across `done`, errors, and subsequent `start` commands.
- **Address arithmetic**: word addresses wrap modulo 2^(addr_width-2) with no error.
- **Reset**, including in the middle of a burst, sets:
  - state = IDLE; `cyc`, `stb`, `busy`, `done`, `error` = 0.
  - FIFO emptied (`out_valid` = 0).
  - `adr` = 0; `cti` = 3'b000.

## Timing
- Latency from `start` to bus:
  - `start` in cycle 0 → `busy` in cycle 1, PLAN in cycle 1, `cyc`/`stb` high in cycle 2.
- Acknowledges:
  - `ack` is sampled only while `cyc` = 1; `ack` while `cyc` = 0 is ignored.
  - A zero-wait slave completes an L-beat burst in L cycles of `cyc` high.
  - Slave wait states (`ack` low) hold `adr`, `cti`, and `cyc` unchanged.
- A pushed word is visible on `out_valid`/`out_data` the cycle after its ack.
- `done` pulses 2 cycles after the final ack (GAP is skipped; FINISH is registered).
- A zero-length request: `start` at cycle 0 gives a `done` pulse at cycle 2 and no bus activity.

## Test plan
- **Zero-wait slave, data = address, base 0x100, count 3, `out_ready` = 1**
  - Expect one burst with `adr` 0x100/0x104/0x108 and `cti` 010, 010, 111.
  - Stream outputs 0x100, 0x104, 0x108; one `done` pulse; `error` = 0.
- **Count 10, `MAX_BURST` 4, `out_ready` = 1**
  - Expect bursts of 4, 4, 2, each separated by a `cyc`-low gap.
  - Expect 10 words in order.
- **Count 20, `out_ready` = 0 until the FIFO is full**
  - Expect bursts totalling 8 words, then `cyc` stays low.
  - After `out_ready` rises, fetching resumes; all 20 words arrive in order and the FIFO never overflows.
- **Slave asserts `err` on the 2nd beat of a 4-beat burst**
  - Only 1 word is pushed; `cyc` drops next cycle.
  - `error` = 1 and `done` pulses; a second `start` clears `error`.
- **Edge cases**
  - `word_count` = 0: no `cyc`, and `done` pulses at cycle 2.
  - `start` pulsed while `busy`: ignored.
  - Single-word request: `cti` = 000.
- **Reset mid-burst**
  - `rst` for one cycle in BURST gives, next cycle: `cyc` = 0, `out_valid` = 0, `busy` = 0.
  - A new `start` then works normally.
